// File: rtl/led_matrix_if.sv
// Signal bundle between the game core side and the LED matrix scanner.
interface led_matrix_if;
    logic       en;
    logic       count0;
    logic       count1;
    logic       count2;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] col_sel;
    logic [7:0] row_r;
    logic [7:0] row_g;
    logic       frame_done;
    logic [2:0] scan_col;

    // Game core / board side: supplies enable and row data, observes the scan.
    modport master (
        output en, in_r, in_g,
        input  count0, count1, count2, col_sel, row_r, row_g, frame_done, scan_col
    );

    // Scanner side.
    modport slave (
        input  en, in_r, in_g,
        output count0, count1, count2, col_sel, row_r, row_g, frame_done, scan_col
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed scanner for the 8x8 red/green LED matrix.
// Each column: present index to the game core, wait for its row outputs to
// settle, latch them, light the column, then blank before the next column.
module led_matrix_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DWELL_CYCLES  = 1000,
    parameter int unsigned BLANK_CYCLES  = 16
) (
    input  logic         clk,
    input  logic         rst,
    led_matrix_if.slave  bus
);

    localparam int unsigned MAX_SD  = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int unsigned MAX_P   = (MAX_SD > BLANK_CYCLES) ? MAX_SD : BLANK_CYCLES;
    localparam int unsigned TIMER_W = $clog2(MAX_P) + 1;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned ROW_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SHOW   = 2'd2,
        BLANK  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ROW_W-1:0]     lat_r_q, lat_r_d;
    logic [ROW_W-1:0]     lat_g_q, lat_g_d;
    logic [ROW_W-1:0]     col_sel_q, col_sel_d;
    logic [ROW_W-1:0]     row_r_q, row_r_d;
    logic [ROW_W-1:0]     row_g_q, row_g_d;
    logic                 frame_done_q, frame_done_d;
    logic [ROW_W-1:0]     col_onehot;

    assign col_onehot = 8'b0000_0001 << col_q;

    // State, column, timer, sample latches and registered drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            timer_q      <= '0;
            lat_r_q      <= '0;
            lat_g_q      <= '0;
            col_sel_q    <= '0;
            row_r_q      <= '0;
            row_g_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            timer_q      <= timer_d;
            lat_r_q      <= lat_r_d;
            lat_g_q      <= lat_g_d;
            col_sel_q    <= col_sel_d;
            row_r_q      <= row_r_d;
            row_g_q      <= row_g_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic; drives are computed for the state being entered so
    // the registered outputs line up with the state cycle-for-cycle.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        timer_d      = timer_q;
        lat_r_d      = lat_r_q;
        lat_g_d      = lat_g_q;
        col_sel_d    = '0;
        row_r_d      = '0;
        row_g_d      = '0;
        frame_done_d = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            col_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    col_d   = '0;
                    timer_d = TIMER_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (timer_q == '0) begin
                        // Single sampling edge for the game core's row outputs.
                        lat_r_d   = bus.in_r;
                        lat_g_d   = bus.in_g;
                        state_d   = SHOW;
                        timer_d   = TIMER_W'(DWELL_CYCLES - 1);
                        col_sel_d = col_onehot;
                        row_r_d   = bus.in_r;
                        row_g_d   = bus.in_g;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                SHOW: begin
                    if (timer_q == '0) begin
                        state_d = BLANK;
                        timer_d = TIMER_W'(BLANK_CYCLES - 1);
                    end else begin
                        timer_d   = timer_q - TIMER_W'(1);
                        col_sel_d = col_onehot;
                        row_r_d   = lat_r_q;
                        row_g_d   = lat_g_q;
                    end
                end
                BLANK: begin
                    if (timer_q == '0) begin
                        state_d      = SETTLE;
                        col_d        = col_q + COL_W'(1);
                        timer_d      = TIMER_W'(SETTLE_CYCLES - 1);
                        frame_done_d = (col_q == COL_W'(7));
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    col_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign bus.count0     = col_q[0];
    assign bus.count1     = col_q[1];
    assign bus.count2     = col_q[2];
    assign bus.scan_col   = col_q;
    assign bus.col_sel    = col_sel_q;
    assign bus.row_r      = row_r_q;
    assign bus.row_g      = row_g_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Drives the 8x8 red/green LED matrix from the game core's per-column row outputs.
- Generates the 3-bit column index (count0..count2) that the game core decodes.
- Samples the returned outR/outG row vectors after a settle interval and drives the physical matrix one column at a time.
- Inserts a blanking gap between columns to prevent ghosting and pulses frame_done once per full 8-column sweep.
- Sits between the game core and the board's matrix pins.

Parameters:
SETTLE_CYCLES, 2, cycles between a count change and the sampling of in_r/in_g (>=1)
DWELL_CYCLES, 1000, cycles a column is lit (>=1)
BLANK_CYCLES, 16, cycles all LEDs are off after each column (>=1)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; low forces blank and IDLE
count0  output  1  column index bit 0 (LSB) to game core
count1  output  1  column index bit 1
count2  output  1  column index bit 2 (MSB)
in_r  input  8  game core outR, bit i = row i, red
in_g  input  8  game core outG, bit i = row i, green
col_sel  output  8  one-hot column drive, active-high, bit c = column c
row_r  output  8  red row drive, active-high
row_g  output  8  green row drive, active-high
frame_done  output  1  one-cycle pulse at end of column 7 blank
scan_col  output  3  current column, debug mirror of count2..0

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE; column counter 0; count0..2 = 0; col_sel = 0; row_r = 0; row_g = 0; frame_done = 0; scan_col = 0; sample latches = 0; timer = 0. All outputs are registered.
- States are IDLE, SETTLE, SHOW and BLANK. The timer is sized to clog2(max parameter)+1 bits and reloads on every state entry.
- IDLE: all drives 0. The first clk edge with en=1 moves to SETTLE with column 0.
- SETTLE:
  - count holds the current column; col_sel, row_r and row_g are 0.
  - Lasts exactly SETTLE_CYCLES cycles.
  - On the last cycle, in_r/in_g are captured into the latches. The input is sampled on that edge only.
  - Then goes to SHOW.
- SHOW:
  - col_sel = one-hot of the current column; row_r/row_g = the latches.
  - Lasts exactly DWELL_CYCLES cycles.
  - Input changes during SHOW do not affect the outputs.
  - Then goes to BLANK.
- BLANK:
  - col_sel, row_r and row_g are 0; count still holds the current column.
  - Lasts exactly BLANK_CYCLES cycles.
  - On exit, the column increments modulo 8 (7 wraps to 0) and the block goes to SETTLE.
  - frame_done = 1 for exactly the one cycle following the exit of column 7's BLANK, coincident with the first SETTLE cycle of column 0.
- Per-column period is SETTLE_CYCLES + DWELL_CYCLES + BLANK_CYCLES. Frame period is 8x that.
- col_sel and the row drives are never nonzero simultaneously outside SHOW. The column changes only while blanked.
- en deasserted in any state:
  - Next edge: IDLE; column = 0; all drives 0; no frame_done.
  - On re-enable, the scan restarts at column 0 with a full SETTLE.
- rst asserted mid-scan: all outputs clear immediately (asynchronous). The scan restarts from IDLE after release.
- in_r = in_g = 0 in a column: the column is still scanned for its full period with rows dark.
- Both colour bits set for a row: both row_r and row_g are driven (yellow).

Test Plan:
1. Reset check, with SETTLE=2, DWELL=4, BLANK=2: assert rst mid-SHOW -> col_sel, row_r, row_g, count and frame_done read 0 in the same cycle, before any clock edge.
2. Sweep, same parameters: hold en=1, in_r = 8'h01 << count, in_g = 0. Required response:
   - count steps 0..7 every 8 cycles.
   - col_sel = 8'h01 for 4 cycles, then 8'h02, and so on.
   - row_r = 8'h01, then 8'h02, and so on.
   - frame_done pulses once every 64 cycles.
3. Sampling window: change in_g from 8'h00 to 8'hFF during SHOW of column 3 -> row_g stays 8'h00 until column 4's SHOW, which shows 8'hFF.
4. Blanking: check every cycle -> col_sel != 0 only in SHOW; in SETTLE/BLANK, col_sel = row_r = row_g = 0; count never changes while col_sel != 0.
5. Wrap and frame_done: run 3 frames -> count goes 7 -> 0; frame_done is high for exactly 1 cycle per frame, in the first SETTLE cycle of column 0.
6. Enable drop: deassert en during column 5 SHOW -> next cycle all drives 0 and count = 0. Reassert en -> column 0 SETTLE begins, and the first frame_done arrives 64 cycles after scanning resumes.
